// File: rtl/mul_slave_defs.sv
// Shared register offsets, control/status bit positions and FSM encoding
// for the shift-add multiplier slave.
package mul_slave_defs;

    localparam logic [4:0] OFS_OPA    = 5'h00;
    localparam logic [4:0] OFS_OPB    = 5'h01;
    localparam logic [4:0] OFS_CTRL   = 5'h02;
    localparam logic [4:0] OFS_STATUS = 5'h03;
    localparam logic [4:0] OFS_RES_L  = 5'h04;
    localparam logic [4:0] OFS_RES_H  = 5'h05;
    localparam logic [4:0] OFS_INT_EN = 5'h06;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_CLEAR_BIT  = 1;
    localparam int STAT_BUSY_BIT   = 0;
    localparam int STAT_DONE_BIT   = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/mul_core.sv
// Radix-2 shift-add unsigned multiplier: one partial product per cycle,
// exactly DATA_W cycles per operation, result held until the next run.
module mul_core
    import mul_slave_defs::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  clear,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    mul_state_t            r_state;
    logic [2*DATA_W-1:0]   r_mcand;
    logic [DATA_W-1:0]     r_mplier;
    logic [2*DATA_W-1:0]   r_acc;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic [2*DATA_W-1:0]   r_product;
    logic [2*DATA_W-1:0]   w_acc_next;

    // The final step's sum is loaded straight into the result so it lands
    // on the same edge that ends EXEC.
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else if (clear) begin
            r_state   <= ST_IDLE;
            r_acc     <= '0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_mcand  <= {{DATA_W{1'b0}}, a};
                        r_mplier <= b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_done   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (r_cnt == CNT_LAST) begin
                        r_product <= w_acc_next;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: rtl/mul_slave.sv
// Bus-mapped multiplier slave: operand/enable registers, CTRL decode and
// the combinational read mux in front of mul_core.
module mul_slave
    import mul_slave_defs::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              S_sel,
    input  logic              S_wr,
    input  logic [ADDR_W-1:0] S_addr,
    input  logic [DATA_W-1:0] S_din,
    output logic [DATA_W-1:0] S_dout,
    output logic              m_interrupt
);

    logic [DATA_W-1:0]   r_opa;
    logic [DATA_W-1:0]   r_opb;
    logic                r_int_en;
    logic [4:0]          w_ofs;
    logic                w_wr_en;
    logic                w_start;
    logic                w_clear;
    logic                w_busy;
    logic                w_done;
    logic [2*DATA_W-1:0] w_product;
    logic [DATA_W-1:0]   w_rdata;
    logic                w_unused_addr;

    assign w_ofs         = S_addr[4:0];
    assign w_unused_addr = &{1'b0, S_addr[ADDR_W-1:5]};
    assign w_wr_en       = S_sel & S_wr;
    assign w_start       = w_wr_en && (w_ofs == OFS_CTRL) && S_din[CTRL_START_BIT];
    assign w_clear       = w_wr_en && (w_ofs == OFS_CTRL) && S_din[CTRL_CLEAR_BIT];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_opa    <= '0;
            r_opb    <= '0;
            r_int_en <= 1'b0;
        end else if (w_wr_en) begin
            case (w_ofs)
                OFS_OPA:    r_opa    <= S_din;
                OFS_OPB:    r_opb    <= S_din;
                OFS_INT_EN: r_int_en <= S_din[0];
                default:    ;
            endcase
        end
    end

    mul_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (w_start),
        .clear   (w_clear),
        .a       (r_opa),
        .b       (r_opb),
        .busy    (w_busy),
        .done    (w_done),
        .product (w_product)
    );

    always_comb begin
        w_rdata = '0;
        case (w_ofs)
            OFS_OPA:    w_rdata = r_opa;
            OFS_OPB:    w_rdata = r_opb;
            OFS_STATUS: begin
                w_rdata[STAT_BUSY_BIT] = w_busy;
                w_rdata[STAT_DONE_BIT] = w_done;
            end
            OFS_RES_L:  w_rdata = w_product[DATA_W-1:0];
            OFS_RES_H:  w_rdata = w_product[2*DATA_W-1:DATA_W];
            OFS_INT_EN: w_rdata[0] = r_int_en;
            default:    w_rdata = '0;
        endcase
    end

    assign S_dout      = (S_sel && !S_wr) ? w_rdata : '0;
    assign m_interrupt = w_done & r_int_en;

endmodule

// File: tb/tb_mul_slave.sv
// Directed-vector bench for mul_slave: register access, latency, results,
// interference, abort, interrupt and decode behaviour.
module tb_mul_slave;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              S_sel;
    logic              S_wr;
    logic [ADDR_W-1:0] S_addr;
    logic [DATA_W-1:0] S_din;
    logic [DATA_W-1:0] S_dout;
    logic              m_interrupt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    mul_slave #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .S_sel       (S_sel),
        .S_wr        (S_wr),
        .S_addr      (S_addr),
        .S_din       (S_din),
        .S_dout      (S_dout),
        .m_interrupt (m_interrupt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [7:0] addr, input logic [31:0] data);
        @(negedge clk);
        S_sel  = 1'b1;
        S_wr   = 1'b1;
        S_addr = addr;
        S_din  = data;
        @(posedge clk);
        #1;
        S_sel  = 1'b0;
        S_wr   = 1'b0;
        S_din  = '0;
    endtask

    task automatic bus_rd(input logic [7:0] addr, output logic [31:0] data);
        S_sel  = 1'b1;
        S_wr   = 1'b0;
        S_addr = addr;
        #1;
        data   = S_dout;
        S_sel  = 1'b0;
    endtask

    // Polls STATUS once per cycle; latency is edges from the start edge to done.
    task automatic wait_done(input int k, output int lat, output int busy_n);
        logic [31:0] v;
        lat    = -1;
        busy_n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            bus_rd(8'h03, v);
            if (v[1]) begin
                lat = cyc - k;
                break;
            end
            if (v[0]) busy_n++;
        end
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input string tag);
        logic [31:0] lo, hi;
        int k, lat, bn;
        bus_wr(8'h00, a);
        bus_wr(8'h01, b);
        bus_wr(8'h02, 32'h1);
        k = cyc;
        wait_done(k, lat, bn);
        chk({tag, "_latency"}, 64'(lat), 64'd32);
        chk({tag, "_busy_cycles"}, 64'(bn), 64'd32);
        bus_rd(8'h04, lo);
        bus_rd(8'h05, hi);
        chk({tag, "_product"}, {hi, lo}, exp);
    endtask

    initial begin
        logic [31:0] v;
        int k, lat, bn;

        reset_n = 1'b0;
        S_sel   = 1'b0;
        S_wr    = 1'b0;
        S_addr  = '0;
        S_din   = '0;

        // Reset: all offsets read 0
        repeat (2) @(posedge clk);
        #1;
        for (int a = 0; a < 7; a++) begin
            bus_rd(8'(a), v);
            chk($sformatf("reset_ofs%0d", a), 64'(v), 64'd0);
        end
        chk("reset_irq", 64'(m_interrupt), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Register readback and CTRL reads 0
        bus_wr(8'h00, 32'h1234_5678);
        bus_wr(8'h01, 32'h9ABC_DEF0);
        bus_rd(8'h00, v); chk("opa_rb", 64'(v), 64'h1234_5678);
        bus_rd(8'h01, v); chk("opb_rb", 64'(v), 64'h9ABC_DEF0);
        bus_rd(8'h02, v); chk("ctrl_rd0", 64'(v), 64'd0);
        bus_wr(8'h1F, 32'hFFFF_FFFF);
        bus_rd(8'h1F, v); chk("ofs1f_rd0", 64'(v), 64'd0);
        S_sel = 1'b0; S_wr = 1'b0; S_addr = 8'h00; #1;
        chk("unsel_rd0", 64'(S_dout), 64'd0);

        // Basic, maximum and zero operands
        run_mul(32'h0000_000A, 32'h0000_000B, 64'h0000_0000_0000_006E, "basic");
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "max");
        run_mul(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, "carry");

        // Result holds previous product during EXEC
        bus_wr(8'h00, 32'd2);
        bus_wr(8'h01, 32'd3);
        bus_wr(8'h02, 32'h1);
        @(negedge clk);
        bus_rd(8'h03, v); chk("exec_status", 64'(v), 64'd1);
        bus_rd(8'h04, v); chk("hold_res_l", 64'(v), 64'h0);
        bus_rd(8'h05, v); chk("hold_res_h", 64'(v), 64'h1);
        wait_done(cyc - 1, lat, bn);
        bus_rd(8'h04, v); chk("small_res_l", 64'(v), 64'd6);

        run_mul(32'h0000_0000, 32'h0000_0005, 64'd0, "zero");

        // Interference: operand write and second start during EXEC
        bus_wr(8'h00, 32'd3);
        bus_wr(8'h01, 32'd7);
        bus_wr(8'h02, 32'h1);
        k = cyc;
        repeat (4) @(posedge clk);
        bus_wr(8'h00, 32'h5);
        bus_wr(8'h02, 32'h1);
        wait_done(k, lat, bn);
        chk("intf_latency", 64'(lat), 64'd32);
        bus_rd(8'h04, v); chk("intf_res_l", 64'(v), 64'd21);
        bus_rd(8'h00, v); chk("intf_opa", 64'(v), 64'h5);

        // Abort with clear at EXEC cycle 10
        bus_wr(8'h00, 32'hFFFF_FFFF);
        bus_wr(8'h01, 32'h2);
        bus_wr(8'h02, 32'h1);
        repeat (9) @(posedge clk);
        bus_wr(8'h02, 32'h2);
        bus_rd(8'h03, v); chk("abort_status", 64'(v), 64'd0);
        bus_rd(8'h04, v); chk("abort_res_l", 64'(v), 64'd0);
        bus_rd(8'h05, v); chk("abort_res_h", 64'(v), 64'd0);
        bus_wr(8'h02, 32'h3);
        repeat (40) @(posedge clk);
        #1;
        bus_rd(8'h03, v); chk("both_status", 64'(v), 64'd0);
        bus_rd(8'h04, v); chk("both_res_l", 64'(v), 64'd0);

        // Interrupt follows done and drops on the next start
        bus_wr(8'h06, 32'h1);
        bus_rd(8'h06, v); chk("int_en_rb", 64'(v), 64'd1);
        bus_wr(8'h00, 32'd4);
        bus_wr(8'h01, 32'd5);
        bus_wr(8'h02, 32'h1);
        k = cyc;
        chk("irq_busy", 64'(m_interrupt), 64'd0);
        wait_done(k, lat, bn);
        chk("irq_latency", 64'(lat), 64'd32);
        chk("irq_done", 64'(m_interrupt), 64'd1);
        bus_rd(8'h04, v); chk("irq_res_l", 64'(v), 64'd20);
        bus_wr(8'h02, 32'h1);
        chk("irq_restart", 64'(m_interrupt), 64'd0);
        bus_wr(8'h06, 32'h0);
        wait_done(cyc, lat, bn);
        chk("irq_masked", 64'(m_interrupt), 64'd0);

        // Reset mid-operation zeroes everything
        bus_wr(8'h02, 32'h1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        bus_rd(8'h03, v); chk("rst_exec_status", 64'(v), 64'd0);
        bus_rd(8'h04, v); chk("rst_exec_res_l", 64'(v), 64'd0);
        bus_rd(8'h00, v); chk("rst_exec_opa", 64'(v), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_slave.md
MUL_SLAVE -- requirements
Module: mul_slave

Interface
REQ-001 Parameter DATA_W, default 32, operand and bus data width.
REQ-002 Parameter ADDR_W, default 8, bus address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 S_sel  input  1  slave select from the bus decoder.
REQ-006 S_wr  input  1  1 = write, 0 = read; qualified by S_sel.
REQ-007 S_addr  input  ADDR_W  register offset; only S_addr[4:0] decoded.
REQ-008 S_din  input  DATA_W  write data from the bus.
REQ-009 S_dout  output  DATA_W  read data to the bus.
REQ-010 m_interrupt  output  1  level interrupt = done AND int_en.

Function
REQ-011 Register map (S_addr[4:0]); all other offsets SHALL read 0 and ignore writes:
- 0x00 OPA R/W
- 0x01 OPB R/W
- 0x02 CTRL W, bit0 start, bit1 clear; self-clearing; reads 0
- 0x03 STATUS RO, bit0 busy, bit1 done
- 0x04 RES_L RO
- 0x05 RES_H RO
- 0x06 INT_EN R/W, bit0
REQ-012 Write SHALL occur at the rising edge where S_sel=1 and S_wr=1.
REQ-013 S_dout SHALL combinationally return the addressed register when S_sel=1 and S_wr=0; otherwise 0.
REQ-014 Operation SHALL be an unsigned DATA_W x DATA_W multiply producing a 2*DATA_W product, with the high half in RES_H and the low half in RES_L.
REQ-015 FSM SHALL have states IDLE, EXEC, DONE; reset SHALL enter IDLE.
REQ-016 A start write in IDLE or DONE SHALL do all of the following at that edge: copy OPA/OPB into internal working registers, zero the accumulator and counter, clear done, and enter EXEC.
REQ-017 EXEC SHALL perform one radix-2 shift-add step per cycle; after exactly DATA_W EXEC cycles it SHALL load RES_H/RES_L, set done, and enter DONE.
REQ-018 With start written at edge k, STATUS.busy SHALL be 1 from edge k until edge k+DATA_W, and done plus valid results SHALL appear at edge k+DATA_W.
REQ-019 RES_H/RES_L SHALL hold the last completed product during EXEC.
REQ-020 A start write during EXEC SHALL be ignored.
REQ-021 OPA/OPB writes during EXEC SHALL update the registers but not the running operation.
REQ-022 A clear write in any state SHALL do all of the following: enter IDLE, zero RES_H, RES_L and the accumulator, and clear busy and done.
REQ-023 When start and clear are set in the same write, clear SHALL win.
REQ-024 DONE SHALL persist until a start or clear write.
REQ-025 Multiplying by zero SHALL take the full DATA_W cycles, with no early exit.

Reset
REQ-026 While reset_n=0 at a rising edge, the following SHALL be zeroed: OPA, OPB, INT_EN, RES_H, RES_L, the working registers, and the counter; done=0 and busy=0.
REQ-027 Reset during EXEC SHALL abort the operation with no result update.
REQ-028 While in reset, S_dout SHALL be 0 for unselected reads and m_interrupt SHALL be 0 after the first reset edge.

Structure
REQ-029 The register offsets, CTRL/STATUS bit positions and FSM state encodings SHALL live in the shared define/package file mul_slave_defs.
REQ-030 The shift-add datapath SHALL be the sub-module mul_core, which has ports clk, reset_n, start, clear, a, b, busy, done and product.
REQ-031 mul_slave SHALL contain only the register file, address decode and read mux.

Verification
REQ-032 Reset: reset_n=0 for 2 cycles, then read all offsets -> all 0, m_interrupt=0.
REQ-033 Basic: OPA=0x0000000A, OPB=0x0000000B, start -> busy for 32 cycles, then done=1, RES_L=0x0000006E, RES_H=0.
REQ-034 Max: OPA=OPB=0xFFFFFFFF -> RES_H=0xFFFFFFFE, RES_L=0x00000001.
REQ-035 Interference: during EXEC, write OPA=0x5 and start again -> result still from original operands; done at the original edge+32.
REQ-036 Abort: clear at EXEC cycle 10 -> next cycle STATUS=0 and RES_L=RES_H=0; a CTRL write of 0x3 -> IDLE, no operation.
REQ-037 Interrupt and decode: INT_EN=1 -> m_interrupt rises with done and falls on the next start; a read with S_sel=0 -> S_dout=0; a read of offset 0x1F -> 0.
